// File: rtl/secded_encoder.sv
// Streaming Hamming SECDED encoder: 32-bit data words in, 39-bit codewords out.
// Two register stages with full backpressure, single-shot error injection for
// exercising downstream decoders, and optional internal tlast framing.
module secded_encoder #(
    parameter int FRAME_LENGTH  = 0,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [31:0]              data_in_tdata,
    input  logic                     data_in_tvalid,
    output logic                     data_in_tready,
    input  logic                     data_in_tlast,

    output logic [39:0]              data_out_tdata,
    output logic                     data_out_tvalid,
    input  logic                     data_out_tready,
    output logic                     data_out_tlast,

    input  logic                     inject_valid,
    input  logic [5:0]               inject_position,
    output logic                     inject_pending,

    output logic [COUNTER_WIDTH-1:0] encoded_count
);

    // Scatter the 32 data bits over the non-power-of-two Hamming positions
    // 3,5,6,7,9..15,17..31,33..38. Position p lives in bit p-1; the parity
    // slots are left at zero here and filled in by add_hamming.
    function automatic logic [37:0] place_data(input logic [31:0] data);
        logic [37:0] code;
        int          d;
        code = '0;
        d    = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                code[6'(p - 1)] = data[5'(d)];
                d++;
            end
        end
        return code;
    endfunction

    // Parity at position 2^k covers every position whose index has bit k set.
    // Parity slots are still zero on entry, so including them is harmless.
    function automatic logic [37:0] add_hamming(input logic [37:0] code);
        logic [37:0] result;
        logic        parity;
        result = code;
        for (int k = 0; k < 6; k++) begin
            parity = 1'b0;
            for (int p = 1; p <= 38; p++) begin
                if (((p >> k) & 1) != 0) begin
                    parity ^= code[6'(p - 1)];
                end
            end
            result[6'((1 << k) - 1)] = parity;
        end
        return result;
    endfunction

    // One-hot flip mask for injection; positions past the codeword give none.
    function automatic logic [38:0] flip_mask(input logic       enable,
                                              input logic [5:0] position);
        logic [38:0] mask;
        mask = '0;
        if (enable && (position < 6'd39)) begin
            mask[position] = 1'b1;
        end
        return mask;
    endfunction

    logic        adv;
    logic        accept;
    logic        word_last;

    logic        pending_position_valid;
    logic [5:0]  pending_position;
    logic        inject_request;
    logic [5:0]  inject_select;

    logic        s1_valid;
    logic [37:0] s1_code;
    logic        s1_last;
    logic        s1_inject;
    logic [5:0]  s1_position;

    logic [38:0] s2_code;

    // The whole pipeline moves together whenever the output slot is free or
    // being drained; input is refused during reset so nothing is half-accepted.
    assign adv            = !data_out_tvalid || data_out_tready;
    assign data_in_tready = adv && !reset;
    assign accept         = data_in_tvalid && data_in_tready;
    assign inject_pending = pending_position_valid;

    // Either internal frame counting or plain pass-through of the input tlast.
    generate
        if (FRAME_LENGTH > 0) begin : g_frame
            localparam int FW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
            localparam logic [FW-1:0] LAST_INDEX = FW'(FRAME_LENGTH - 1);

            logic [FW-1:0] frame_count;
            logic          unused_tlast;

            assign unused_tlast = data_in_tlast;
            assign word_last    = (frame_count == LAST_INDEX);

            // Count accepted words, wrapping after the frame's last word.
            always_ff @(posedge clock) begin
                if (reset) begin
                    frame_count <= '0;
                end else if (accept) begin
                    frame_count <= word_last ? '0 : frame_count + FW'(1);
                end
            end
        end else begin : g_passthrough
            assign word_last = data_in_tlast;
        end
    endgenerate

    // A request raised in the same cycle as a handshake wins over an older
    // pending one, so its position is the one that reaches the word.
    always_comb begin
        inject_request = inject_valid || pending_position_valid;
        inject_select  = inject_valid ? inject_position : pending_position;
    end

    // Arm injection on request; the next accepted word consumes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_position_valid <= 1'b0;
            pending_position       <= '0;
        end else if (accept) begin
            pending_position_valid <= 1'b0;
        end else if (inject_valid) begin
            pending_position_valid <= 1'b1;
            pending_position       <= inject_position;
        end
    end

    // Stage 1: capture the Hamming-coded word with its tlast and injection tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_last     <= 1'b0;
            s1_inject   <= 1'b0;
            s1_position <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_code     <= add_hamming(place_data(data_in_tdata));
                s1_last     <= word_last;
                s1_inject   <= inject_request;
                s1_position <= inject_select;
            end
        end
    end

    // Overall parity is taken over the clean word, then the flip is applied,
    // so an injected single-bit error looks exactly like a channel error.
    always_comb begin
        s2_code = {^s1_code, s1_code} ^ flip_mask(s1_inject, s1_position);
    end

    // Stage 2: output register, held while the consumer stalls us.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_tvalid <= 1'b0;
            data_out_tdata  <= '0;
            data_out_tlast  <= 1'b0;
        end else if (adv) begin
            data_out_tvalid <= s1_valid;
            if (s1_valid) begin
                data_out_tdata <= {1'b0, s2_code};
                data_out_tlast <= s1_last;
            end
        end
    end

    // Count codewords actually handed to the consumer; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            encoded_count <= '0;
        end else if (data_out_tvalid && data_out_tready) begin
            encoded_count <= encoded_count + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_secded_encoder.sv
// Testbench for secded_encoder: constant vectors, randomized traffic against a
// syndrome-based reference encoder, backpressure, injection, framing and reset.
module tb_secded_encoder;

    logic        clock = 1'b0;
    logic        reset;

    logic [31:0] data_in_tdata;
    logic        data_in_tvalid;
    logic        data_in_tready;
    logic        data_in_tlast;

    logic [39:0] data_out_tdata;
    logic        data_out_tvalid;
    logic        data_out_tready;
    logic        data_out_tlast;

    logic        inject_valid;
    logic [5:0]  inject_position;
    logic        inject_pending;
    logic [31:0] encoded_count;

    logic        f_in_tready;
    logic [39:0] f_tdata;
    logic        f_tvalid;
    logic        f_tlast;
    logic        f_pending;
    logic [31:0] f_count;

    int          checks = 0;
    int          failures = 0;

    logic [39:0] exp_data[$];
    logic        exp_last[$];
    logic [39:0] got_data[$];
    logic        got_last[$];
    logic        got_frame_last[$];

    int          ready_mode = 0;
    int          stall_violations = 0;
    logic        prev_stall = 1'b0;
    logic [39:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always #5 clock = ~clock;

    secded_encoder #(.FRAME_LENGTH(0), .COUNTER_WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .data_in_tdata   (data_in_tdata),
        .data_in_tvalid  (data_in_tvalid),
        .data_in_tready  (data_in_tready),
        .data_in_tlast   (data_in_tlast),
        .data_out_tdata  (data_out_tdata),
        .data_out_tvalid (data_out_tvalid),
        .data_out_tready (data_out_tready),
        .data_out_tlast  (data_out_tlast),
        .inject_valid    (inject_valid),
        .inject_position (inject_position),
        .inject_pending  (inject_pending),
        .encoded_count   (encoded_count)
    );

    secded_encoder #(.FRAME_LENGTH(4), .COUNTER_WIDTH(32)) dut_frame (
        .clock           (clock),
        .reset           (reset),
        .data_in_tdata   (data_in_tdata),
        .data_in_tvalid  (data_in_tvalid),
        .data_in_tready  (f_in_tready),
        .data_in_tlast   (data_in_tlast),
        .data_out_tdata  (f_tdata),
        .data_out_tvalid (f_tvalid),
        .data_out_tready (data_out_tready),
        .data_out_tlast  (f_tlast),
        .inject_valid    (inject_valid),
        .inject_position (inject_position),
        .inject_pending  (f_pending),
        .encoded_count   (f_count)
    );

    // Reference: data bits go to non-power-of-two positions in order; the
    // parity bits are the XOR of the positions of all set data bits, which
    // makes the syndrome of the whole word zero. Bit 38 gives even parity.
    function automatic logic [39:0] ref_encode(input logic [31:0] d);
        logic [39:0] cw;
        int          pos;
        int          syn;
        cw  = '0;
        pos = 2;
        syn = 0;
        for (int i = 0; i < 32; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[5'(i)]) begin
                cw[6'(pos - 1)] = 1'b1;
                syn = syn ^ pos;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (((syn >> k) & 1) != 0) cw[6'((1 << k) - 1)] = 1'b1;
        end
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    function automatic logic [39:0] inject_mask(input int pos);
        logic [39:0] m;
        m = '0;
        if (pos < 39) m[6'(pos)] = 1'b1;
        return m;
    endfunction

    // Output ready pattern: 0 holds the value the test set, 1 toggles, 2 random.
    always @(posedge clock) begin
        #1;
        if (ready_mode == 1) data_out_tready = !data_out_tready;
        else if (ready_mode == 2) data_out_tready = 1'($urandom_range(0, 1));
    end

    // Record every output handshake of both instances.
    always @(negedge clock) begin
        if (!reset && data_out_tvalid && data_out_tready) begin
            got_data.push_back(data_out_tdata);
            got_last.push_back(data_out_tlast);
        end
        if (!reset && f_tvalid && data_out_tready) begin
            got_frame_last.push_back(f_tlast);
        end
    end

    // Watch for outputs that change or drop while stalled.
    always @(negedge clock) begin
        if (!reset && prev_stall &&
            !(data_out_tvalid && data_out_tdata === prev_data && data_out_tlast === prev_last)) begin
            stall_violations <= stall_violations + 1;
        end
        prev_stall <= !reset && data_out_tvalid && !data_out_tready;
        prev_data  <= data_out_tdata;
        prev_last  <= data_out_tlast;
    end

    task automatic clear_queues();
        exp_data.delete();
        exp_last.delete();
        got_data.delete();
        got_last.delete();
        got_frame_last.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_queues();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [39:0] expected);
        int waited;
        waited         = 0;
        data_in_tdata  = d;
        data_in_tlast  = l;
        data_in_tvalid = 1'b1;
        @(negedge clock);
        while (!data_in_tready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!data_in_tready) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout tready=%b required=1", data_in_tready);
        end else begin
            exp_data.push_back(expected);
            exp_last.push_back(l);
        end
        @(posedge clock);
        #1;
        data_in_tvalid = 1'b0;
        data_in_tlast  = 1'b0;
    endtask

    task automatic pulse_inject(input logic [5:0] pos);
        inject_valid    = 1'b1;
        inject_position = pos;
        @(posedge clock);
        #1;
        inject_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (got_data.size() < exp_data.size() && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (got_data.size() < exp_data.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout got=%0d required=%0d", got_data.size(), exp_data.size());
        end
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        data_in_tvalid  = 1'b0;
        data_in_tdata   = '0;
        data_in_tlast   = 1'b0;
        data_out_tready = 1'b1;
        inject_valid    = 1'b0;
        inject_position = '0;
        ready_mode      = 0;
        reset           = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_queues();
        @(negedge clock);
        checks++;
        if (data_out_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b required=0", data_out_tvalid); end
        checks++;
        if (data_out_tdata !== 40'd0) begin failures++; $display("[TB] FAIL reset_data got=%h required=0", data_out_tdata); end
        checks++;
        if (data_out_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b required=0", data_out_tlast); end
        checks++;
        if (inject_pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending got=%b required=0", inject_pending); end
        checks++;
        if (encoded_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d required=0", encoded_count); end
        checks++;
        if (data_in_tready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tready got=%b required=1", data_in_tready); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_known_vectors();
        apply_reset();
        ready_mode      = 0;
        data_out_tready = 1'b1;
        send_word(32'h0000_0000, 1'b0, 40'h00_0000_0000);
        @(negedge clock);
        checks++;
        if (data_out_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early valid=%b required=0", data_out_tvalid); end
        @(negedge clock);
        checks++;
        if (data_out_tvalid !== 1'b1 || data_out_tdata !== 40'h00_0000_0000) begin
            failures++;
            $display("[TB] FAIL latency_two valid=%b data=%h required valid=1 data=0", data_out_tvalid, data_out_tdata);
        end
        @(negedge clock);
        checks++;
        if (encoded_count !== 32'd1) begin failures++; $display("[TB] FAIL count_one got=%0d required=1", encoded_count); end
        @(posedge clock);
        #1;
        send_word(32'h0000_0001, 1'b0, 40'h40_0000_0007);
        send_word(32'h8000_0000, 1'b0, 40'h20_8000_000A);
        drain();
        checks++;
        if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL known_size got=%0d required=%0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i]) begin failures++; $display("[TB] FAIL known_word[%0d] got=%h required=%h", i, got_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        l;
        int          pos;
        logic [39:0] e;
        apply_reset();
        stall_violations = 0;
        ready_mode       = 2;
        for (int n = 0; n < 40; n++) begin
            d = $urandom();
            l = 1'($urandom_range(0, 1));
            e = ref_encode(d);
            if ($urandom_range(0, 7) == 0) begin
                pos             = int'($urandom_range(0, 63));
                inject_valid    = 1'b1;
                inject_position = 6'(pos);
                e               = e ^ inject_mask(pos);
            end
            send_word(d, l, e);
            inject_valid = 1'b0;
        end
        drain();
        ready_mode = 0;
        checks++;
        if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL random_size got=%0d required=%0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("[TB] FAIL random_word[%0d] got=%h/%b required=%h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (stall_violations != 0) begin failures++; $display("[TB] FAIL random_stall_stable violations=%0d required=0", stall_violations); end
        checks++;
        if (encoded_count !== 32'(exp_data.size())) begin failures++; $display("[TB] FAIL random_count got=%0d required=%0d", encoded_count, exp_data.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        apply_reset();
        stall_violations = 0;
        data_out_tready  = 1'b1;
        ready_mode       = 1;
        for (int n = 0; n < 8; n++) begin
            d = $urandom();
            send_word(d, 1'b0, ref_encode(d));
        end
        drain();
        ready_mode      = 0;
        data_out_tready = 1'b1;
        checks++;
        if (got_data.size() != 8) begin failures++; $display("[TB] FAIL b2b_size got=%0d required=8", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i]) begin failures++; $display("[TB] FAIL b2b_word[%0d] got=%h required=%h", i, got_data[i], exp_data[i]); end
        end
        checks++;
        if (stall_violations != 0) begin failures++; $display("[TB] FAIL b2b_stall_stable violations=%0d required=0", stall_violations); end
        checks++;
        if (encoded_count !== 32'd8) begin failures++; $display("[TB] FAIL b2b_count got=%0d required=8", encoded_count); end
    endtask

    task automatic test_injection();
        logic [31:0] d;
        apply_reset();
        ready_mode      = 0;
        data_out_tready = 1'b1;
        pulse_inject(6'd5);
        @(negedge clock);
        checks++;
        if (inject_pending !== 1'b1) begin failures++; $display("[TB] FAIL inj_armed got=%b required=1", inject_pending); end
        @(posedge clock);
        #1;
        send_word(32'h0000_0001, 1'b0, 40'h40_0000_0027);
        @(negedge clock);
        checks++;
        if (inject_pending !== 1'b0) begin failures++; $display("[TB] FAIL inj_consumed got=%b required=0", inject_pending); end
        @(posedge clock);
        #1;
        send_word(32'h0000_0001, 1'b0, 40'h40_0000_0007);
        pulse_inject(6'd3);
        pulse_inject(6'd10);
        d = 32'h1234_5678;
        send_word(d, 1'b0, ref_encode(d) ^ (40'd1 << 10));
        inject_valid    = 1'b1;
        inject_position = 6'd0;
        d = 32'hCAFE_F00D;
        send_word(d, 1'b0, ref_encode(d) ^ 40'd1);
        inject_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (inject_pending !== 1'b0) begin failures++; $display("[TB] FAIL inj_same_cycle_pending got=%b required=0", inject_pending); end
        @(posedge clock);
        #1;
        pulse_inject(6'd45);
        @(negedge clock);
        checks++;
        if (inject_pending !== 1'b1) begin failures++; $display("[TB] FAIL inj_range_armed got=%b required=1", inject_pending); end
        @(posedge clock);
        #1;
        d = 32'hDEAD_BEEF;
        send_word(d, 1'b0, ref_encode(d));
        pulse_inject(6'd38);
        d = 32'h0F0F_0F0F;
        send_word(d, 1'b0, ref_encode(d) ^ (40'd1 << 38));
        drain();
        checks++;
        if (inject_pending !== 1'b0) begin failures++; $display("[TB] FAIL inj_range_consumed got=%b required=0", inject_pending); end
        checks++;
        if (got_data.size() != exp_data.size()) begin failures++; $display("[TB] FAIL inj_size got=%0d required=%0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i]) begin failures++; $display("[TB] FAIL inj_word[%0d] got=%h required=%h", i, got_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        apply_reset();
        ready_mode      = 0;
        data_out_tready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d = $urandom();
            send_word(d, (n == 2), ref_encode(d));
        end
        drain();
        checks++;
        if (got_frame_last.size() != 10 || got_last.size() != 10) begin
            failures++;
            $display("[TB] FAIL frame_size got=%0d/%0d required=10", got_frame_last.size(), got_last.size());
        end
        for (int i = 0; i < 10 && i < got_frame_last.size() && i < got_last.size(); i++) begin
            checks++;
            if (got_frame_last[i] !== ((i % 4) == 3)) begin
                failures++;
                $display("[TB] FAIL frame_gen_last[%0d] got=%b required=%b", i, got_frame_last[i], (i % 4) == 3);
            end
            checks++;
            if (got_last[i] !== (i == 2)) begin
                failures++;
                $display("[TB] FAIL frame_pass_last[%0d] got=%b required=%b", i, got_last[i], i == 2);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        ready_mode      = 0;
        data_out_tready = 1'b1;
        send_word(32'h0000_00FF, 1'b0, ref_encode(32'h0000_00FF));
        drain();
        data_out_tready = 1'b0;
        send_word(32'h1111_1111, 1'b0, ref_encode(32'h1111_1111));
        send_word(32'h2222_2222, 1'b0, ref_encode(32'h2222_2222));
        pulse_inject(6'd7);
        @(negedge clock);
        checks++;
        if (inject_pending !== 1'b1 || encoded_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL mid_before pending=%b count=%0d required pending=1 count=1", inject_pending, encoded_count);
        end
        apply_reset();
        data_out_tready = 1'b1;
        @(negedge clock);
        checks++;
        if (data_out_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b required=0", data_out_tvalid); end
        checks++;
        if (inject_pending !== 1'b0) begin failures++; $display("[TB] FAIL mid_pending got=%b required=0", inject_pending); end
        checks++;
        if (encoded_count !== 32'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d required=0", encoded_count); end
        checks++;
        if (data_in_tready !== 1'b1) begin failures++; $display("[TB] FAIL mid_tready got=%b required=1", data_in_tready); end
        repeat (5) @(negedge clock);
        checks++;
        if (got_data.size() != 0) begin failures++; $display("[TB] FAIL mid_flushed got=%0d words required=0", got_data.size()); end
        @(posedge clock);
        #1;
        send_word(32'h0000_0001, 1'b0, 40'h40_0000_0007);
        drain();
        checks++;
        if (got_data.size() != 1) begin failures++; $display("[TB] FAIL mid_after_size got=%0d required=1", got_data.size()); end
        if (got_data.size() > 0) begin
            checks++;
            if (got_data[0] !== 40'h40_0000_0007) begin failures++; $display("[TB] FAIL mid_after_word got=%h required=4000000007", got_data[0]); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_back_to_back();
        test_injection();
        test_framing();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
